load_store_unit: RTL

- Initiator side of the data-memory port: accepts load/store requests from the execute stage and drives the word-wide memory (mem_addr, mem_wdata, mem_we).
- The memory has a combinational read while mem_we=0 and a posedge write while mem_we=1.
- Handles RV32I sub-word accesses: byte/half extraction with sign/zero extension on loads, read-modify-write on SB/SH since the memory has no byte enables.
- Returns a single valid/ready response to the pipeline.

---
 rtl/lsu_pkg.sv | 10 +
 rtl/lsu_byte_lane.sv | 42 ++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and wait-counter width for the load/store unit
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int CNT_W = 4;
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: little-endian lane select with load extension and store read-modify-write merge
//   word_i    memory word read back
//   addr_lo_i byte offset within the word
//   funct3_i  RV32I width code
//   wdata_i   store data (low byte/half used for SB/SH)
//   load_o    extended load result
//   store_o   word to write back (merged for SB/SH, wdata_i for SW)
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = word_i[8*addr_lo_i +: 8];
    assign h = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    always_comb begin
        load_o  = '0;
        store_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                load_o = {{24{b[7]}}, b};
                store_o = word_i;
                store_o[8*addr_lo_i +: 8] = wdata_i[7:0];
            end
            F3_H: begin
                load_o = {{16{h[15]}}, h};
                store_o = word_i;
                store_o[16*addr_lo_i[1] +: 16] = wdata_i[15:0];
            end
            F3_W:    load_o = word_i;
            F3_BU:   load_o = {24'h0, b};
            F3_HU:   load_o = {16'h0, h};
            default: load_o = '0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory initiator with sub-word loads and RMW sub-word stores
//   req_*  load/store request from execute (valid/ready)
//   rsp_*  single response back to the pipeline (valid/ready), rsp_err = rejected access
//   mem_*  word-wide memory: combinational read, posedge write on mem_we
//   Build option: define MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int MEM_AW      = 30,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);
    localparam logic [CNT_W-1:0] WAIT_N = CNT_W'(WAIT_CYCLES);
    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [MEM_AW-1:0] maddr_q, maddr_d;
    logic [31:0]       mwdata_q, mwdata_d;
    logic [31:0]       load_val, store_word;
    logic              bad;

    lsu_byte_lane u_lane (
        .word_i    (mem_rdata),
        .addr_lo_i (lo_q),
        .funct3_i  (f3_q),
        .wdata_i   (wdata_q),
        .load_o    (load_val),
        .store_o   (store_word)
    );

    // Unsigned widths exist only for loads, so LBU/LHU codes with we=1 are illegal.
    always_comb begin
        bad = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_funct3[2] && req_we);
`ifdef MISALIGN_TRAP_EN
        bad = bad || (req_funct3[1:0] == 2'b01 && req_addr[0])
                  || (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
`else
        bad = bad;
`endif
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        f3_d     = f3_q;
        lo_d     = lo_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d    = req_we;
                f3_d    = req_funct3;
                lo_d    = req_addr[1:0];
                wdata_d = req_wdata;
                rdata_d = '0;
                err_d   = bad;
                cnt_d   = '0;
                if (bad) state_d = RESP;
                else begin
                    maddr_d = req_addr[ADDR_W-1:2];
                    if (req_we) mwdata_d = req_wdata;
                    state_d = (req_we && req_funct3 == F3_W) ? WRITE : READ;
                end
            end
            READ: if (cnt_q == WAIT_N) begin
                cnt_d = '0;
                if (we_q) begin
                    mwdata_d = store_word;
                    state_d  = WRITE;
                end else begin
                    rdata_d = load_val;
                    state_d = RESP;
                end
            end else cnt_d = cnt_q + 1'b1;
            WRITE:   state_d = RESP;
            RESP:    state_d = rsp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            lo_q     <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            f3_q     <= f3_d;
            lo_q     <= lo_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    // Strobe decodes straight from state so reset drops it asynchronously.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign mem_we    = (state_q == WRITE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
endmodule
